// File: rtl/cmu_phi_mac_if.sv
// Bundle between the phi MAC, its requester and the shared fp adder/multiplier.
// master = requester plus arithmetic units, slave = the MAC sequencer.
interface cmu_phi_mac_if #(
    parameter int unsigned DBL_WIDTH = 64,
    parameter int unsigned N_TERMS   = 4
);
    localparam int unsigned VW = N_TERMS * DBL_WIDTH;

    logic                 start;
    logic                 busy;
    logic [DBL_WIDTH-1:0] base;
    logic [VW-1:0]        coef;
    logic [VW-1:0]        p;
    logic [VW-1:0]        q;
    logic [N_TERMS-1:0]   preadd_mask;
    logic [DBL_WIDTH-1:0] a;
    logic                 valid_out;
    logic                 timeout_err;

    logic                 add_valid;
    logic [DBL_WIDTH-1:0] add_a;
    logic [DBL_WIDTH-1:0] add_b;
    logic                 add_finish;
    logic [DBL_WIDTH-1:0] add_result;

    logic                 mul_valid;
    logic [DBL_WIDTH-1:0] mul_a;
    logic [DBL_WIDTH-1:0] mul_b;
    logic                 mul_finish;
    logic [DBL_WIDTH-1:0] mul_result;

    modport master (
        output start, base, coef, p, q, preadd_mask,
        input  busy, a, valid_out, timeout_err,
        input  add_valid, add_a, add_b, mul_valid, mul_a, mul_b,
        output add_finish, add_result, mul_finish, mul_result
    );

    modport slave (
        input  start, base, coef, p, q, preadd_mask,
        output busy, a, valid_out, timeout_err,
        output add_valid, add_a, add_b, mul_valid, mul_a, mul_b,
        input  add_finish, add_result, mul_finish, mul_result
    );
endinterface

// File: rtl/cmu_phi_mac.sv
// Sequencer computing a = base + sum(coef_k * t_k) on one shared fp adder and
// one fp multiplier, t_k = p_k (+ q_k when preadd_mask[k]); terms run in order.
module cmu_phi_mac #(
    parameter int unsigned DBL_WIDTH = 64,
    parameter int unsigned N_TERMS   = 4,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic         clk,
    input  logic         rst,
    cmu_phi_mac_if.slave bus_s
);
    localparam int unsigned VW = N_TERMS * DBL_WIDTH;
    localparam int unsigned KW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [KW-1:0] K_LAST = KW'(N_TERMS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_MUL, S_ACC, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [KW-1:0]        k_q, k_d, j;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [VW-1:0]        coef_q, p_q, q_q, coef_s, p_s, q_s;
    logic [N_TERMS-1:0]   mask_q, mask_s;
    logic [DBL_WIDTH-1:0] acc_q, acc_d, a_q, a_d;
    logic [DBL_WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
    logic [DBL_WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic                 valid_q, valid_d, terr_q, terr_d, busy_q, busy_d;
    logic                 add_go_q, add_go_d, mul_go_q, mul_go_d;
    logic                 take, waiting, fin, issue;

    // Operands come from the live inputs on the accepting cycle, latched copies afterwards.
    assign take    = (state_q == S_IDLE) && bus_s.start;
    assign coef_s  = take ? bus_s.coef        : coef_q;
    assign p_s     = take ? bus_s.p           : p_q;
    assign q_s     = take ? bus_s.q           : q_q;
    assign mask_s  = take ? bus_s.preadd_mask : mask_q;
    assign waiting = (state_q == S_PRE) || (state_q == S_MUL) || (state_q == S_ACC);
    assign fin     = (state_q == S_MUL) ? bus_s.mul_finish : bus_s.add_finish;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q + CW'(1);
        acc_d    = acc_q;
        a_d      = a_q;
        valid_d  = 1'b0;
        terr_d   = 1'b0;
        add_go_d = 1'b0;
        mul_go_d = 1'b0;
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        issue    = 1'b0;
        j        = k_q;
        busy_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (take) begin
                    acc_d = bus_s.base;
                    j     = '0;
                    issue = 1'b1;
                end
            end
            S_PRE: if (fin) begin
                state_d  = S_MUL;
                cnt_d    = '0;
                mul_go_d = 1'b1;
                mul_a_d  = coef_s[k_q*DBL_WIDTH +: DBL_WIDTH];
                mul_b_d  = bus_s.add_result;
            end
            S_MUL: if (fin) begin
                state_d  = S_ACC;
                cnt_d    = '0;
                add_go_d = 1'b1;
                add_a_d  = acc_q;
                add_b_d  = bus_s.mul_result;
            end
            S_ACC: if (fin) begin
                acc_d = bus_s.add_result;
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                    a_d     = bus_s.add_result;
                    valid_d = 1'b1;
                end else begin
                    j     = k_q + KW'(1);
                    issue = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // A finish on the last allowed cycle still wins over the abort.
        if (waiting && !fin && (cnt_q == C_LAST)) begin
            state_d = S_IDLE;
            terr_d  = 1'b1;
        end

        if (issue) begin
            k_d   = j;
            cnt_d = '0;
            if (mask_s[j]) begin
                state_d  = S_PRE;
                add_go_d = 1'b1;
                add_a_d  = p_s[j*DBL_WIDTH +: DBL_WIDTH];
                add_b_d  = q_s[j*DBL_WIDTH +: DBL_WIDTH];
            end else begin
                state_d  = S_MUL;
                mul_go_d = 1'b1;
                mul_a_d  = coef_s[j*DBL_WIDTH +: DBL_WIDTH];
                mul_b_d  = p_s[j*DBL_WIDTH +: DBL_WIDTH];
            end
        end

        // busy falls together with the valid_out pulse, so the DONE cycle reads idle.
        busy_d = (state_d == S_PRE) || (state_d == S_MUL) || (state_d == S_ACC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            cnt_q    <= '0;
            coef_q   <= '0;
            p_q      <= '0;
            q_q      <= '0;
            mask_q   <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            valid_q  <= 1'b0;
            terr_q   <= 1'b0;
            busy_q   <= 1'b0;
            add_go_q <= 1'b0;
            mul_go_q <= 1'b0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            valid_q  <= valid_d;
            terr_q   <= terr_d;
            busy_q   <= busy_d;
            add_go_q <= add_go_d;
            mul_go_q <= mul_go_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            if (take) begin
                coef_q <= bus_s.coef;
                p_q    <= bus_s.p;
                q_q    <= bus_s.q;
                mask_q <= bus_s.preadd_mask;
            end
        end
    end

    assign bus_s.busy        = busy_q;
    assign bus_s.a           = a_q;
    assign bus_s.valid_out   = valid_q;
    assign bus_s.timeout_err = terr_q;
    assign bus_s.add_valid   = add_go_q;
    assign bus_s.add_a       = add_a_q;
    assign bus_s.add_b       = add_b_q;
    assign bus_s.mul_valid   = mul_go_q;
    assign bus_s.mul_a       = mul_a_q;
    assign bus_s.mul_b       = mul_b_q;
endmodule

// File: tb/tb_cmu_phi_mac.sv
// Bench for cmu_phi_mac: real-valued fp unit models with fixed latency, a
// per-cycle output monitor fed by an arithmetic model, and directed runs.
module tb_cmu_phi_mac;
    localparam int unsigned DW = 64;
    localparam int unsigned NT = 4;
    localparam int unsigned TO = 64;
    localparam int unsigned L  = 3;
    localparam int unsigned VW = DW * NT;

    localparam logic [DW-1:0] ONE  = 64'h3FF0000000000000;
    localparam logic [DW-1:0] TWO  = 64'h4000000000000000;
    localparam logic [DW-1:0] FIVE = 64'h4014000000000000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cmu_phi_mac_if #(.DBL_WIDTH(DW), .N_TERMS(NT)) bus ();

    cmu_phi_mac #(.DBL_WIDTH(DW), .N_TERMS(NT), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus_s(bus)
    );

    int vecs = 0;
    int errs = 0;

    logic [DW-1:0] model_a = '0;
    logic [DW-1:0] exp_a   = '0;
    bit  run_on = 1'b0;
    bit  exp_to = 1'b0;
    int  run_c  = 0;
    int  exp_c  = 0;
    int  seen_valid_c = -1;
    int  seen_err_c   = -1;
    int  seen_mulgo_c = -1;

    bit  mul_hang = 1'b0;
    bit  mul_kick = 1'b0;
    int  add_cnt  = 0;
    int  mul_cnt  = 0;
    logic [DW-1:0] add_pend, mul_pend;

    // fp units: finish is seen L cycles after go is seen.
    always @(posedge clk) begin
        bus.add_finish <= 1'b0;
        if (add_cnt > 0) begin
            add_cnt <= add_cnt - 1;
            if (add_cnt == 1) begin
                bus.add_finish <= 1'b1;
                bus.add_result <= add_pend;
            end
        end
        if (bus.add_valid) begin
            add_cnt  <= L - 1;
            add_pend <= $realtobits($bitstoreal(bus.add_a) + $bitstoreal(bus.add_b));
        end
    end

    always @(posedge clk) begin
        bus.mul_finish <= 1'b0;
        if (mul_cnt > 0) begin
            mul_cnt <= mul_cnt - 1;
            if (mul_cnt == 1) begin
                bus.mul_finish <= 1'b1;
                bus.mul_result <= mul_pend;
            end
        end
        if (bus.mul_valid && !mul_hang) begin
            mul_cnt  <= L - 1;
            mul_pend <= $realtobits($bitstoreal(bus.mul_a) * $bitstoreal(bus.mul_b));
        end
        if (mul_kick) begin
            bus.mul_finish <= 1'b1;
            bus.mul_result <= 64'h4059000000000000;
        end
    end

    function automatic logic [DW-1:0] model_mac(input logic [DW-1:0] b, input logic [VW-1:0] c,
                                                 input logic [VW-1:0] pp, input logic [VW-1:0] qq,
                                                 input logic [NT-1:0] m);
        real acc, t;
        acc = $bitstoreal(b);
        for (int k = 0; k < NT; k++) begin
            t = $bitstoreal(pp[k*DW +: DW]);
            if (m[k]) t = t + $bitstoreal(qq[k*DW +: DW]);
            acc = acc + $bitstoreal(c[k*DW +: DW]) * t;
        end
        return $realtobits(acc);
    endfunction

    function automatic int model_done_cycle(input logic [NT-1:0] m);
        return (2 * NT + $countones(m)) * (L + 1) + 1;
    endfunction

    function automatic int model_timeout_cycle(input logic [NT-1:0] m);
        return (m[0] ? (L + 1) : 0) + 1 + TO;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Every cycle: {busy, valid_out, timeout_err, a} against the model's view.
    always @(negedge clk) begin : mon
        logic [DW+2:0] act, req;
        act = {bus.busy, bus.valid_out, bus.timeout_err, bus.a};
        if (rst) begin
            req = '0;
        end else if (run_on) begin
            run_c++;
            if (bus.mul_valid)   seen_mulgo_c = run_c;
            if (bus.valid_out)   seen_valid_c = run_c;
            if (bus.timeout_err) seen_err_c   = run_c;
            if (run_c == exp_c) begin
                if (!exp_to) model_a = exp_a;
                req = {1'b0, !exp_to, exp_to, model_a};
                run_on = 1'b0;
            end else begin
                req = {1'b1, 2'b00, model_a};
            end
        end else begin
            req = {3'b000, model_a};
        end
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL cycle_outputs t=%0t run_c=%0d busy/valid/terr/a got %h required %h",
                     $time, run_c, act, req);
        end
    end

    task automatic do_run(input logic [DW-1:0] b, input logic [VW-1:0] c, input logic [VW-1:0] pp,
                          input logic [VW-1:0] qq, input logic [NT-1:0] m,
                          input bit disturb, input int rst_at);
        bus.base        = b;
        bus.coef        = c;
        bus.p           = pp;
        bus.q           = qq;
        bus.preadd_mask = m;
        bus.start       = 1'b1;
        @(posedge clk);
        exp_a        = model_mac(b, c, pp, qq, m);
        exp_to       = mul_hang;
        exp_c        = mul_hang ? model_timeout_cycle(m) : model_done_cycle(m);
        run_c        = 0;
        seen_valid_c = -1;
        seen_err_c   = -1;
        seen_mulgo_c = -1;
        run_on       = 1'b1;
        #1 bus.start = 1'b0;
        while (run_on) begin
            @(posedge clk);
            #2;
            if (disturb) begin
                bus.start       = (run_c % 3) != 0;
                bus.base        = FIVE;
                bus.coef        = {NT{FIVE}};
                bus.p           = {NT{TWO}};
                bus.q           = {NT{FIVE}};
                bus.preadd_mask = ~m;
            end
            if (rst_at > 0 && run_c == rst_at) begin
                rst     = 1'b1;
                run_on  = 1'b0;
                model_a = '0;
                #1;
                chk("rst_async_busy", 64'(bus.busy), 64'd0);
                chk("rst_async_a", bus.a, 64'd0);
                repeat (2) @(posedge clk);
                #2 rst = 1'b0;
            end
        end
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errs=%0d required 0", errs);
        $fatal(1);
    end

    initial begin
        bus.start       = 1'b0;
        bus.base        = '0;
        bus.coef        = '0;
        bus.p           = '0;
        bus.q           = '0;
        bus.preadd_mask = '0;
        #1 rst = 1'b1;
        #2;
        chk("reset_flags", 64'({bus.busy, bus.valid_out, bus.timeout_err}), 64'd0);
        chk("reset_a", bus.a, 64'd0);
        chk("reset_go", 64'({bus.add_valid, bus.mul_valid}), 64'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // All terms pre-added.
        do_run(ONE, {NT{TWO}}, {NT{ONE}}, {NT{ONE}}, 4'b1111, 1'b0, 0);
        chk("a_mask1111", bus.a, 64'h4031000000000000);
        chk("lat_mask1111", 64'(seen_valid_c), 64'd49);

        // No pre-adds.
        do_run(ONE, {NT{TWO}}, {NT{ONE}}, {NT{ONE}}, 4'b0000, 1'b0, 0);
        chk("a_mask0000", bus.a, 64'h4022000000000000);
        chk("lat_mask0000", 64'(seen_valid_c), 64'd33);

        // Mixed mask with start pulses and input churn while busy.
        do_run(ONE, {NT{TWO}}, {NT{ONE}}, {NT{ONE}}, 4'b0101, 1'b1, 0);
        chk("a_mask0101", bus.a, 64'h402A000000000000);
        chk("lat_mask0101", 64'(seen_valid_c), 64'd41);

        // Multiplier never finishes: abort, then a late finish must be ignored.
        mul_hang = 1'b1;
        do_run(ONE, {NT{TWO}}, {NT{ONE}}, {NT{ONE}}, 4'b1111, 1'b0, 0);
        mul_hang = 1'b0;
        chk("timeout_distance", 64'(seen_err_c - seen_mulgo_c), 64'd64);
        chk("timeout_no_valid", 64'(seen_valid_c), 64'(-1));
        chk("timeout_a_kept", bus.a, 64'h402A000000000000);
        mul_kick = 1'b1;
        @(posedge clk);
        #2 mul_kick = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("late_finish_a", bus.a, 64'h402A000000000000);

        // Reset in the middle of a run, then a clean run.
        do_run(ONE, {NT{TWO}}, {NT{ONE}}, {NT{ONE}}, 4'b1111, 1'b0, 20);
        chk("post_rst_a", bus.a, 64'd0);
        do_run(ONE, {NT{TWO}}, {NT{ONE}}, {NT{ONE}}, 4'b1111, 1'b0, 0);
        chk("rerun_a", bus.a, 64'h4031000000000000);
        chk("rerun_lat", 64'(seen_valid_c), 64'd49);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
